// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_NRD      = 2;

    // Widest address slice and packed address vector the helper can unpack
    localparam int unsigned RF_ADDR_MAX = 16;
    localparam int unsigned RF_NRD_MAX  = 4;
    localparam int unsigned RF_VEC_MAX  = RF_ADDR_MAX * RF_NRD_MAX;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Extract read-port k's address from a packed vector of aw-bit slices
    function automatic logic [RF_ADDR_MAX-1:0] rf_port_addr(
        input logic [RF_VEC_MAX-1:0] vec,
        input int unsigned           k,
        input int unsigned           aw
    );
        logic [RF_VEC_MAX-1:0]  shifted;
        logic [RF_ADDR_MAX-1:0] mask;
        shifted = vec >> (k * aw);
        mask    = (RF_ADDR_MAX'(1) << aw) - RF_ADDR_MAX'(1);
        return RF_ADDR_MAX'(shifted) & mask;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address mux, optional bypass, zero-register
// masking and masking while the array is still being cleared.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]                   addr_i,
    input  logic [(1 << ADDR_W)*DATA_W-1:0]     mem_flat_i,
    input  logic                                run_i,
    input  logic                                byp_en_i,
    input  logic [ADDR_W-1:0]                   byp_addr_i,
    input  logic [DATA_W-1:0]                   byp_data_i,
    output logic [DATA_W-1:0]                   data_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] arr_c;
    logic              zero_c;

    // Select the addressed entry from the flattened array
    always_comb begin
        arr_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_i == ADDR_W'(i)) begin
                arr_c = mem_flat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign zero_c = (ZERO_REG != 0) && (addr_i == '0);

    // Forward a same-cycle write if enabled, then apply the masks last
    always_comb begin
        data_o = arr_c;
        if (byp_en_i && (byp_addr_i == addr_i)) begin
            data_o = byp_data_i;
        end
        if (zero_c || !run_i) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with debug port and post-reset clear sweep.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NRD      = RF_NRD,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   rd_addr_i,
    output logic [NRD*DATA_W-1:0]   rd_data_o,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [ADDR_W-1:0]       dbg_index_i,
    output logic [DATA_W-1:0]       dbg_data_o,
    output logic                    ready_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    rf_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;

    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_waddr_c;
    logic [DATA_W-1:0]  mem_wdata_c;

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DEPTH*DATA_W-1:0] mem_flat_c;

    logic run_c;
    logic byp_en_c;

    // State and clear-pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state and array write port: sweep zeros in CLEAR, user writes in RUN
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = waddr_i;
        mem_wdata_c = wdata_i;
        case (state_q)
            RF_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_cnt_q;
                mem_wdata_c = '0;
                clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                mem_we_c = we_i && !((ZERO_REG != 0) && (waddr_i == '0));
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
        if (reset) begin
            mem_we_c = 1'b0;
        end
    end

    // Storage array, deliberately without reset so it maps to RAM
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat_c[g*DATA_W +: DATA_W] = mem_q[g];
    end

    assign run_c   = (state_q == RF_RUN);
    assign ready_o = run_c;

`ifdef RF_BYPASS_EN
    assign byp_en_c = run_c && we_i;
`else
    assign byp_en_c = 1'b0;
`endif

    // Read ports, one per packed address slice
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        assign addr_k = ADDR_W'(rf_port_addr(RF_VEC_MAX'(rd_addr_i), k, ADDR_W));

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .addr_i     (addr_k),
            .mem_flat_i (mem_flat_c),
            .run_i      (run_c),
            .byp_en_i   (byp_en_c),
            .byp_addr_i (waddr_i),
            .byp_data_i (wdata_i),
            .data_o     (rd_data_o[k*DATA_W +: DATA_W])
        );
    end

    // Debug port never forwards in-flight writes
    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_dbg_port (
        .addr_i     (dbg_index_i),
        .mem_flat_i (mem_flat_c),
        .run_i      (run_c),
        .byp_en_i   (1'b0),
        .byp_addr_i (waddr_i),
        .byp_data_i (wdata_i),
        .data_o     (dbg_data_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default and 4-port/16-bit builds).
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic        we_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [4:0]  dbg_index_a;
    logic [31:0] dbg_data_a;
    logic        ready_a;

    logic [15:0] rd_addr_b;
    logic [63:0] rd_data_b;
    logic        we_b;
    logic [3:0]  waddr_b;
    logic [15:0] wdata_b;
    logic [3:0]  dbg_index_b;
    logic [15:0] dbg_data_b;
    logic        ready_b;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    regfile_mp u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .rd_addr_i   (rd_addr_a),
        .rd_data_o   (rd_data_a),
        .we_i        (we_a),
        .waddr_i     (waddr_a),
        .wdata_i     (wdata_a),
        .dbg_index_i (dbg_index_a),
        .dbg_data_o  (dbg_data_a),
        .ready_o     (ready_a)
    );

    regfile_mp #(
        .DATA_W (16),
        .ADDR_W (4),
        .NRD    (4)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .rd_addr_i   (rd_addr_b),
        .rd_data_o   (rd_data_b),
        .we_i        (we_b),
        .waddr_i     (waddr_b),
        .wdata_i     (wdata_b),
        .dbg_index_i (dbg_index_b),
        .dbg_data_o  (dbg_data_b),
        .ready_o     (ready_b)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
        we_a = 1'b1; waddr_a = a; wdata_a = d;
        step();
        we_a = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [15:0] d);
        we_b = 1'b1; waddr_b = a; wdata_b = d;
        step();
        we_b = 1'b0;
    endtask

    logic [31:0] exp_byp;
    logic [4:0]  av;

    initial begin
        reset = 1'b1;
        rd_addr_a = '0; we_a = 1'b0; waddr_a = '0; wdata_a = '0; dbg_index_a = '0;
        rd_addr_b = '0; we_b = 1'b0; waddr_b = '0; wdata_b = '0; dbg_index_b = '0;

        // Reset state
        step();
        check_vec("rst_ready_a", 64'(ready_a), 64'd0);
        check_vec("rst_ready_b", 64'(ready_b), 64'd0);
        check_vec("rst_rd_a",    rd_data_a,    64'd0);
        check_vec("rst_dbg_a",   64'(dbg_data_a), 64'd0);
        reset = 1'b0;

        // Clear sweep length: 32 edges for A, 16 for B
        for (int e = 1; e <= 32; e++) begin
            step();
            check_vec($sformatf("clr_ready_a_e%0d", e), 64'(ready_a), 64'(e == 32));
            check_vec($sformatf("clr_ready_b_e%0d", e), 64'(ready_b), 64'(e >= 16));
        end

        // Every entry reads zero after the sweep
        for (int a = 0; a < 32; a++) begin
            av = 5'(a);
            rd_addr_a = {~av, av};
            dbg_index_a = av;
            #1;
            check_vec($sformatf("zero_p0_r%0d", a), 64'(rd_data_a[31:0]),  64'd0);
            check_vec($sformatf("zero_p1_r%0d", a), 64'(rd_data_a[63:32]), 64'd0);
            check_vec($sformatf("zero_dbg_r%0d", a), 64'(dbg_data_a), 64'd0);
        end

        // Write r5, both ports read it next cycle
        wr_a(5'd5, 32'hDEAD_BEEF);
        rd_addr_a = {5'd5, 5'd5};
        dbg_index_a = 5'd5;
        #1;
        check_vec("r5_p0",  64'(rd_data_a[31:0]),  64'h0000_0000_DEAD_BEEF);
        check_vec("r5_p1",  64'(rd_data_a[63:32]), 64'h0000_0000_DEAD_BEEF);
        check_vec("r5_dbg", 64'(dbg_data_a),       64'h0000_0000_DEAD_BEEF);

        // Writes to r0 are dropped and never forwarded
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h1234_5678;
        rd_addr_a = {5'd5, 5'd0};
        dbg_index_a = 5'd0;
        #1;
        check_vec("r0_same_cycle", 64'(rd_data_a[31:0]), 64'd0);
        step();
        we_a = 1'b0;
        #1;
        check_vec("r0_p0",  64'(rd_data_a[31:0]), 64'd0);
        check_vec("r0_dbg", 64'(dbg_data_a),      64'd0);

        // Same-cycle write/read of r7
        wr_a(5'd7, 32'h0000_0001);
`ifdef RF_BYPASS_EN
        exp_byp = 32'hA5A5_A5A5;
`else
        exp_byp = 32'h0000_0001;
`endif
        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hA5A5_A5A5;
        rd_addr_a = {5'd5, 5'd7};
        dbg_index_a = 5'd7;
        #1;
        check_vec("r7_same_cycle", 64'(rd_data_a[31:0]), 64'(exp_byp));
        check_vec("r7_dbg_same",   64'(dbg_data_a),      64'h1);
        check_vec("r5_untouched",  64'(rd_data_a[63:32]), 64'h0000_0000_DEAD_BEEF);
        step();
        we_a = 1'b0;
        #1;
        check_vec("r7_next_cycle", 64'(rd_data_a[31:0]), 64'h0000_0000_A5A5_A5A5);
        check_vec("r7_dbg_next",   64'(dbg_data_a),      64'h0000_0000_A5A5_A5A5);

        // Reset mid-sweep restarts from entry 0; CLEAR drops writes
        wr_a(5'd9, 32'h0000_FFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        check_vec("mid_ready", 64'(ready_a), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd_addr_a = {5'd9, 5'd5};
        dbg_index_a = 5'd7;
        #1;
        check_vec("clr_mask_p0",  64'(rd_data_a[31:0]),  64'd0);
        check_vec("clr_mask_p1",  64'(rd_data_a[63:32]), 64'd0);
        check_vec("clr_mask_dbg", 64'(dbg_data_a),       64'd0);
        waddr_a = 5'd3; wdata_a = 32'h0000_0055;
        for (int e = 1; e <= 32; e++) begin
            we_a = (e >= 10 && e <= 31);
            step();
            check_vec($sformatf("re_ready_a_e%0d", e), 64'(ready_a), 64'(e == 32));
        end
        we_a = 1'b0;
        rd_addr_a = {5'd3, 5'd9};
        dbg_index_a = 5'd5;
        #1;
        check_vec("r9_after_reset", 64'(rd_data_a[31:0]),  64'd0);
        check_vec("r3_clear_drop",  64'(rd_data_a[63:32]), 64'd0);
        check_vec("r5_after_reset", 64'(dbg_data_a),       64'd0);

        // Four-port, 16-bit build
        check_vec("b_ready", 64'(ready_b), 64'd1);
        for (int i = 1; i < 16; i++) begin
            wr_b(4'(i), 16'(i * 16'h0101));
        end
        rd_addr_b = {4'd8, 4'd15, 4'd8, 4'd1};
        dbg_index_b = 4'd15;
        #1;
        check_vec("b_p0",  64'(rd_data_b[15:0]),  64'h0101);
        check_vec("b_p1",  64'(rd_data_b[31:16]), 64'h0808);
        check_vec("b_p2",  64'(rd_data_b[47:32]), 64'h0F0F);
        check_vec("b_p3",  64'(rd_data_b[63:48]), 64'h0808);
        check_vec("b_dbg", 64'(dbg_data_b),       64'h0F0F);
        rd_addr_b = {4'd0, 4'd2, 4'd12, 4'd14};
        #1;
        check_vec("b_p0_r14", 64'(rd_data_b[15:0]),  64'h0E0E);
        check_vec("b_p1_r12", 64'(rd_data_b[31:16]), 64'h0C0C);
        check_vec("b_p2_r2",  64'(rd_data_b[47:32]), 64'h0202);
        check_vec("b_p3_r0",  64'(rd_data_b[63:48]), 64'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
